// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC core among NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_req_arbiter #(
   parameter  int unsigned NUM_REQ     = 4,
   parameter  int unsigned DATA_W      = 32,
   parameter  int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_target,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_cos,
   output logic                      rsp_err,
   output logic                      core_start,
   output logic [DATA_W-1:0]         core_target,
   input  logic                      core_done,
   input  logic [DATA_W-1:0]         core_cos
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
   logic [ID_W-1:0]   gnt_id, scan_id;
   logic              gnt_found;
   logic              rsp_valid_d, rsp_err_d, core_start_d;
   logic [ID_W-1:0]   rsp_id_d;
   logic [DATA_W-1:0] rsp_cos_d, core_target_d;
   logic [DATA_W-1:0] tgt [NUM_REQ];

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
`endif

   // Unpack the flat target bus into per-requester words.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_tgt
      assign tgt[i] = req_target[i*DATA_W +: DATA_W];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      scan_id   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_id = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!gnt_found && req_valid[scan_id]) begin
            gnt_found = 1'b1;
            gnt_id    = scan_id;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      rr_ptr_d      = rr_ptr;
      req_ready     = '0;
      rsp_valid_d   = rsp_valid;
      rsp_id_d      = rsp_id;
      rsp_cos_d     = rsp_cos;
      rsp_err_d     = rsp_err;
      core_start_d  = 1'b0;
      core_target_d = core_target;
`ifdef CORDIC_ARB_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_id] = 1'b1;
               rsp_id_d          = gnt_id;
               core_target_d     = tgt[gnt_id];
               core_start_d      = 1'b1;
               state_d           = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         WAIT: begin
            // A done arriving on the expiry cycle still yields a normal response.
            if (core_done) begin
               rsp_valid_d = 1'b1;
               rsp_cos_d   = core_cos;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end
`ifdef CORDIC_ARB_TIMEOUT_EN
            else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_cos_d   = '0;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt + CNT_W'(1);
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_cos     <= '0;
         rsp_err     <= 1'b0;
         core_start  <= 1'b0;
         core_target <= '0;
      end else begin
         state       <= state_d;
         rr_ptr      <= rr_ptr_d;
         rsp_valid   <= rsp_valid_d;
         rsp_id      <= rsp_id_d;
         rsp_cos     <= rsp_cos_d;
         rsp_err     <= rsp_err_d;
         core_start  <= core_start_d;
         core_target <= core_target_d;
      end
   end

`ifdef CORDIC_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt <= '0;
      else        tmo_cnt <= tmo_cnt_d;
   end
`endif

endmodule
